lru_victim_ctrl: RTL and testbench

- Replacement-side partner of the 4-way LRU tracker.
- Consumes the tracker's one-hot victim vector and the per-way valid/dirty bits, and picks an allocation way on a miss.
- Sequences dirty-victim writeback and line-fill handshakes with the memory side.
- Produces the one-hot access ("touch") vector plus enable that updates the tracker on hits and on completed fills.
- Sits between the tag-compare stage and the memory interface of the cache.

---
 rtl/lru_victim_ctrl_pkg.sv | 20 ++
 rtl/lru_victim_ctrl_if.sv | 33 +++
 rtl/lru_victim_ctrl_way_prienc4.sv | 14 +
 rtl/lru_victim_ctrl.sv | 156 +++++++++++++++
 tb/tb_lru_victim_ctrl.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/lru_victim_ctrl_pkg.sv
// Shared definitions for the 4-way replacement controller: associativity, FSM encoding
// and the one-hot check used on tracker-supplied way vectors.
package lru_victim_ctrl_pkg;

  localparam int WAYS = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_WB     = 3'd2,
    ST_FILL   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // True when exactly one bit of a way vector is set.
  function automatic logic is_onehot4(input logic [WAYS-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/lru_victim_ctrl_if.sv
// Lookup, tracker and memory-side handshake bundle of the replacement controller.
interface lru_victim_ctrl_if;
  import lru_victim_ctrl_pkg::*;

  logic            miss_req;
  logic            hit;
  logic [WAYS-1:0] hit_way;
  logic [WAYS-1:0] lru_way;
  logic [WAYS-1:0] way_valid;
  logic [WAYS-1:0] way_dirty;
  logic [WAYS-1:0] touch;
  logic            touch_en;
  logic            wb_req;
  logic [WAYS-1:0] wb_way;
  logic            wb_ack;
  logic            fill_req;
  logic [WAYS-1:0] fill_way;
  logic            fill_ack;
  logic            miss_done;
  logic            busy;
  logic            err;

  modport master (
    output miss_req, hit, hit_way, lru_way, way_valid, way_dirty, wb_ack, fill_ack,
    input  touch, touch_en, wb_req, wb_way, fill_req, fill_way, miss_done, busy, err
  );

  modport slave (
    input  miss_req, hit, hit_way, lru_way, way_valid, way_dirty, wb_ack, fill_ack,
    output touch, touch_en, wb_req, wb_way, fill_req, fill_way, miss_done, busy, err
  );

endinterface

// File: rtl/lru_victim_ctrl_way_prienc4.sv
// Lowest-set-bit priority encoder over four ways, producing a one-hot grant and an any-set flag.
module way_prienc4
  import lru_victim_ctrl_pkg::*;
(
  input  logic [WAYS-1:0] req,
  output logic [WAYS-1:0] onehot,
  output logic            any
);

  // Two's-complement trick isolates the lowest set bit.
  assign onehot = req & (~req + 4'd1);
  assign any    = |req;

endmodule

// File: rtl/lru_victim_ctrl.sv
// Miss-side allocation controller: picks a victim way, sequences writeback and fill,
// and issues tracker touches for hits and completed fills.
module lru_victim_ctrl
  import lru_victim_ctrl_pkg::*;
(
  input logic             clk,
  input logic             rst,
  lru_victim_ctrl_if.slave bus
);

  state_e          state_r, state_nxt_s;
  logic [WAYS-1:0] victim_r, victim_nxt_s;
  logic [WAYS-1:0] free_way_s, sel_victim_s;
  logic            free_any_s, bad_lru_s, sel_dirty_s;
  logic [WAYS-1:0] touch_r, touch_nxt_s, wb_way_r, wb_way_nxt_s, fill_way_r, fill_way_nxt_s;
  logic            touch_en_r, touch_en_nxt_s, wb_req_r, wb_req_nxt_s;
  logic            fill_req_r, fill_req_nxt_s, miss_done_r, miss_done_nxt_s;
  logic            busy_r, err_r, err_nxt_s;

  way_prienc4 u_free_enc (
    .req    (~bus.way_valid),
    .onehot (free_way_s),
    .any    (free_any_s)
  );

  // Victim choice: first invalid way, else the tracker's LRU way, else a safe fallback.
  always_comb begin
    sel_victim_s = 4'b0001;
    bad_lru_s    = 1'b0;
    if (free_any_s) begin
      sel_victim_s = free_way_s;
    end else if (is_onehot4(bus.lru_way)) begin
      sel_victim_s = bus.lru_way;
    end else begin
      sel_victim_s = 4'b0001;
      bad_lru_s    = 1'b1;
    end
  end

  assign sel_dirty_s = |(sel_victim_s & bus.way_valid & bus.way_dirty);

  // Next state and next registered outputs.
  always_comb begin
    state_nxt_s     = state_r;
    victim_nxt_s    = victim_r;
    touch_nxt_s     = 4'd0;
    touch_en_nxt_s  = 1'b0;
    wb_req_nxt_s    = 1'b0;
    wb_way_nxt_s    = 4'd0;
    fill_req_nxt_s  = 1'b0;
    fill_way_nxt_s  = 4'd0;
    miss_done_nxt_s = 1'b0;
    err_nxt_s       = err_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.miss_req) begin
          state_nxt_s = ST_SELECT;
          if (bus.hit) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end else if (bus.hit && is_onehot4(bus.hit_way)) begin
          touch_nxt_s    = bus.hit_way;
          touch_en_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SELECT: begin
        victim_nxt_s = sel_victim_s;
        if (bad_lru_s) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
        if (sel_dirty_s) begin
          state_nxt_s  = ST_WB;
          wb_req_nxt_s = 1'b1;
          wb_way_nxt_s = sel_victim_s;
        end else begin
          state_nxt_s    = ST_FILL;
          fill_req_nxt_s = 1'b1;
          fill_way_nxt_s = sel_victim_s;
        end
      end
      ST_WB: begin
        if (bus.wb_ack) begin
          state_nxt_s    = ST_FILL;
          fill_req_nxt_s = 1'b1;
          fill_way_nxt_s = victim_r;
        end else begin
          wb_req_nxt_s = 1'b1;
          wb_way_nxt_s = victim_r;
        end
      end
      ST_FILL: begin
        if (bus.fill_ack) begin
          state_nxt_s     = ST_DONE;
          touch_nxt_s     = victim_r;
          touch_en_nxt_s  = 1'b1;
          miss_done_nxt_s = 1'b1;
        end else begin
          fill_req_nxt_s = 1'b1;
          fill_way_nxt_s = victim_r;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, victim and output registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      victim_r    <= 4'd0;
      touch_r     <= 4'd0;
      touch_en_r  <= 1'b0;
      wb_req_r    <= 1'b0;
      wb_way_r    <= 4'd0;
      fill_req_r  <= 1'b0;
      fill_way_r  <= 4'd0;
      miss_done_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      victim_r    <= victim_nxt_s;
      touch_r     <= touch_nxt_s;
      touch_en_r  <= touch_en_nxt_s;
      wb_req_r    <= wb_req_nxt_s;
      wb_way_r    <= wb_way_nxt_s;
      fill_req_r  <= fill_req_nxt_s;
      fill_way_r  <= fill_way_nxt_s;
      miss_done_r <= miss_done_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      err_r       <= err_nxt_s;
    end
  end

  assign bus.touch     = touch_r;
  assign bus.touch_en  = touch_en_r;
  assign bus.wb_req    = wb_req_r;
  assign bus.wb_way    = wb_way_r;
  assign bus.fill_req  = fill_req_r;
  assign bus.fill_way  = fill_way_r;
  assign bus.miss_done = miss_done_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_lru_victim_ctrl.sv
// Self-checking bench for lru_victim_ctrl: vector table, corner sequences and random transactions.
module tb_lru_victim_ctrl;
  import lru_victim_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lru_victim_ctrl_if bus();
  lru_victim_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  int   n_checks = 0;
  int   n_fail   = 0;
  logic err_model = 1'b0;

  typedef struct {
    logic       h;
    logic       m;
    logic [3:0] hw;
    logic [3:0] lru;
    logic [3:0] valid;
    logic [3:0] dirty;
    int         wbd;
    int         fd;
    logic [3:0] exp_v;
    logic       exp_wb;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference victim rule: first invalid way, else LRU if one-hot, else way 0 with error.
  function automatic logic [3:0] model_victim(input logic [3:0] valid, input logic [3:0] lru,
                                              output logic bad);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!valid[i]) return 4'(1 << i);
    end
    if ($countones(lru) == 1) return lru;
    bad = 1'b1;
    return 4'b0001;
  endfunction

  function automatic logic model_dirty(input logic [3:0] valid, input logic [3:0] dirty,
                                       input logic [3:0] victim);
    for (int i = 0; i < 4; i++) begin
      if (victim[i]) return valid[i] && dirty[i];
    end
    return 1'b0;
  endfunction

  task automatic run_txn(input logic h, input logic m, input logic [3:0] hw, input logic [3:0] lru,
                         input logic [3:0] valid, input logic [3:0] dirty, input int wbd,
                         input int fd, input logic [3:0] exp_v, input logic exp_wb,
                         input string tag);
    logic       bad;
    logic [3:0] unused_v;
    bus.hit = h; bus.miss_req = m; bus.hit_way = hw; bus.lru_way = lru;
    bus.way_valid = valid; bus.way_dirty = dirty; bus.wb_ack = 1'b0; bus.fill_ack = 1'b0;
    if (!m) begin
      tick();
      bus.hit = 1'b0;
      check({tag, " hit touch"}, 32'(bus.touch), 32'(exp_v));
      check({tag, " hit touch_en"}, 32'(bus.touch_en), 32'd1);
      check({tag, " hit no req"}, 32'(bus.wb_req | bus.fill_req), 32'd0);
      check({tag, " hit busy"}, 32'(bus.busy), 32'd0);
      tick();
      check({tag, " hit pulse end"}, 32'({bus.touch_en, bus.touch}), 32'd0);
    end else begin
      unused_v = model_victim(valid, lru, bad);
      err_model = err_model | bad | h;
      tick();
      bus.hit = 1'b0;
      check({tag, " sel busy"}, 32'(bus.busy), 32'd1);
      check({tag, " sel quiet"}, 32'({bus.touch_en, bus.wb_req, bus.fill_req}), 32'd0);
      tick();
      check({tag, " err"}, 32'(bus.err), 32'(err_model));
      if (exp_wb) begin
        check({tag, " wb_req"}, 32'(bus.wb_req), 32'd1);
        check({tag, " wb_way"}, 32'(bus.wb_way), 32'(exp_v));
        check({tag, " no fill in wb"}, 32'(bus.fill_req), 32'd0);
        for (int k = 0; k < wbd; k++) begin
          bus.fill_ack = 1'($urandom);
          tick();
          check({tag, " wb hold"}, 32'({bus.wb_req, bus.fill_req, bus.wb_way}), 32'({2'b10, exp_v}));
        end
        bus.fill_ack = 1'b0;
        bus.wb_ack   = 1'b1;
        tick();
        bus.wb_ack   = 1'b0;
      end
      check({tag, " fill_req"}, 32'(bus.fill_req), 32'd1);
      check({tag, " fill_way"}, 32'(bus.fill_way), 32'(exp_v));
      check({tag, " no wb in fill"}, 32'(bus.wb_req), 32'd0);
      for (int k = 0; k < fd; k++) begin
        bus.wb_ack = 1'($urandom);
        tick();
        check({tag, " fill hold"}, 32'({bus.fill_req, bus.fill_way, bus.miss_done}), 32'({1'b1, exp_v, 1'b0}));
      end
      bus.wb_ack   = 1'b0;
      bus.fill_ack = 1'b1;
      tick();
      bus.fill_ack = 1'b0;
      check({tag, " miss_done"}, 32'(bus.miss_done), 32'd1);
      check({tag, " done touch"}, 32'({bus.touch_en, bus.touch}), 32'({1'b1, exp_v}));
      check({tag, " done busy"}, 32'({bus.busy, bus.fill_req}), 32'b10);
      bus.miss_req = 1'b0;
      tick();
      check({tag, " back idle"}, 32'({bus.busy, bus.miss_done, bus.touch_en}), 32'd0);
      check({tag, " err end"}, 32'(bus.err), 32'(err_model));
    end
  endtask

  initial begin
    logic       bad;
    logic [3:0] v, hw, lru, valid, dirty;
    logic       h, m;

    tbl[0] = '{1'b1, 1'b0, 4'b0100, 4'b0001, 4'b1111, 4'b0000, 0, 0, 4'b0100, 1'b0};
    tbl[1] = '{1'b0, 1'b1, 4'b0000, 4'b0001, 4'b1011, 4'b0000, 0, 2, 4'b0100, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 4'b0000, 4'b1000, 4'b1111, 4'b1000, 2, 1, 4'b1000, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 4'b0000, 4'b0010, 4'b1110, 4'b0001, 0, 0, 4'b0001, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 4'b0000, 4'b0010, 4'b1111, 4'b0010, 0, 0, 4'b0010, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0001, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 4'b0000, 4'b0110, 4'b1111, 4'b0000, 0, 1, 4'b0001, 1'b0};
    tbl[7] = '{1'b1, 1'b1, 4'b0010, 4'b0001, 4'b0111, 4'b1111, 0, 0, 4'b1000, 1'b0};

    bus.miss_req = 1'b0; bus.hit = 1'b0; bus.hit_way = 4'd0; bus.lru_way = 4'd0;
    bus.way_valid = 4'd0; bus.way_dirty = 4'd0; bus.wb_ack = 1'b0; bus.fill_ack = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("reset outputs", 32'({bus.busy, bus.err, bus.touch_en, bus.wb_req, bus.fill_req, bus.miss_done}), 32'd0);
    check("reset ways", 32'({bus.touch, bus.wb_way, bus.fill_way}), 32'd0);
    rst = 1'b1;
    tick();
    check("idle after reset", 32'(bus.busy), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_txn(tbl[i].h, tbl[i].m, tbl[i].hw, tbl[i].lru, tbl[i].valid, tbl[i].dirty,
              tbl[i].wbd, tbl[i].fd, tbl[i].exp_v, tbl[i].exp_wb, $sformatf("vec%0d", i));
    end
    check("err sticky", 32'(bus.err), 32'd1);

    // Stray fill_ack while idle must be ignored.
    bus.fill_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stray ack idle", 32'({bus.busy, bus.fill_req, bus.miss_done, bus.touch_en}), 32'd0);
    end
    bus.fill_ack = 1'b0;

    // Reset in the middle of a writeback.
    bus.miss_req = 1'b1; bus.way_valid = 4'b1111; bus.way_dirty = 4'b0100; bus.lru_way = 4'b0100;
    tick();
    tick();
    check("mid-wb wb_req", 32'({bus.wb_req, bus.wb_way}), 32'({1'b1, 4'b0100}));
    #2 rst = 1'b0;
    #1;
    check("async reset outputs", 32'({bus.busy, bus.err, bus.wb_req, bus.fill_req, bus.miss_done, bus.touch_en}), 32'd0);
    check("async reset ways", 32'({bus.wb_way, bus.fill_way, bus.touch}), 32'd0);
    err_model    = 1'b0;
    bus.miss_req = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("post reset idle", 32'({bus.busy, bus.err, bus.wb_req}), 32'd0);
    run_txn(1'b1, 1'b0, 4'b1000, 4'b0001, 4'b1111, 4'b0000, 0, 0, 4'b1000, 1'b0, "post-rst hit");

    // Randomised transactions checked against the reference rules.
    for (int t = 0; t < 40; t++) begin
      hw = 4'(1 << $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        run_txn(1'b1, 1'b0, hw, 4'd0, 4'd0, 4'd0, 0, 0, hw, 1'b0, $sformatf("rnd%0d", t));
      end else begin
        h     = ($urandom_range(0, 7) == 0);
        m     = 1'b1;
        valid = ($urandom_range(0, 1) == 0) ? 4'b1111 : 4'($urandom);
        dirty = 4'($urandom);
        lru   = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        v     = model_victim(valid, lru, bad);
        run_txn(h, m, hw, lru, valid, dirty, $urandom_range(0, 3), $urandom_range(0, 3),
                v, model_dirty(valid, dirty, v), $sformatf("rnd%0d", t));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
